stack_engine: RTL and testbench
===============================

STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 SHALL have parameter STACK_BASE, 16'hFFFF, empty-stack SP value; equals SP reset value.
REQ-002 SHALL have parameter STACK_LIMIT, 16'hFF00, lowest SP value; a push at this SP is an overflow.
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports op_valid in 1, op_ready out 1, op_push in 1 (1=push, 0=pop), op_data in 16: operation request.
REQ-006 SHALL have ports res_valid out 1, res_data out 16, res_err out 1: one-cycle completion result.
REQ-007 SHALL have ports sp_val in 16 (current SP), sp_push out 1, sp_pop out 1, sp_new out 16: SP register update.
REQ-008 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 16, mem_wdata out 16, mem_rdata in 16, mem_ack in 1: stack memory.
REQ-009 SHALL have ports err_ovf out 1, err_udf out 1: sticky error flags.

Function
REQ-010 SHALL implement FSM IDLE -> MEM -> UPD -> IDLE, plus ERR for rejected operations; all outputs registered.
REQ-011 In IDLE, op_ready SHALL be 1; in all other states it SHALL be 0. An operation is accepted when op_valid&op_ready are 1 at a clock edge.
REQ-012 On acceptance, sp_val, op_push and op_data SHALL be latched; later sp_val changes SHALL NOT affect the operation.
REQ-013 Push SHALL use a post-decrement scheme: write mem[SP] = op_data, then sp_new = SP-1.
REQ-014 Pop SHALL use a pre-increment scheme: read mem[SP+1], then sp_new = SP+1.
REQ-015 All address arithmetic SHALL be 16-bit modulo 2^16.
REQ-016 In MEM, mem_req SHALL be 1, mem_we SHALL equal the latched op_push, and mem_addr/mem_wdata SHALL be stable until mem_ack is sampled 1. Then the FSM SHALL go to UPD; mem_rdata SHALL be captured on that edge for a pop.
REQ-017 mem_ack while mem_req=0 SHALL be ignored; the MEM wait time SHALL be unbounded.
REQ-018 UPD SHALL last exactly one cycle. It SHALL drive:
- sp_push=1 (push) or sp_pop=1 (pop), never both;
- sp_new valid;
- res_valid=1 and res_err=0;
- res_data = captured read data (pop) or 16'h0000 (push).
REQ-019 Latency: with mem_ack high in the first MEM cycle, res_valid SHALL be high in the second cycle after acceptance; each extra wait cycle adds one.
REQ-020 ERR SHALL last one cycle, with res_valid=1, res_err=1, res_data=0, no mem_req, and no sp_push/sp_pop; then the FSM SHALL return to IDLE.
REQ-021 sp_push, sp_pop, mem_req and res_valid SHALL be 0 outside the states named above.
REQ-022 A new operation SHALL be accepted no earlier than the cycle after UPD/ERR; there SHALL be no back-to-back overlap.

Reset
REQ-023 Asynchronous reset SHALL force IDLE and clear all outputs to 0, except op_ready, which SHALL be 1 after reset release.
REQ-024 Reset during MEM SHALL abandon the memory access (mem_req drops immediately) and SHALL NOT pulse sp_push/sp_pop; SP is left unchanged.

Configuration
REQ-025 With macro STACK_BOUNDS_CHECK_EN defined:
- a push with latched SP == STACK_LIMIT SHALL go to ERR and set err_ovf;
- a pop with latched SP == STACK_BASE SHALL go to ERR and set err_udf;
- err_ovf/err_udf SHALL stay set until reset.
REQ-026 Without STACK_BOUNDS_CHECK_EN, the ERR state SHALL be absent, every operation SHALL proceed with SP wrap-around, and res_err, err_ovf and err_udf SHALL be tied 0.

Structure
REQ-027 Package stack_pkg SHALL hold the FSM state typedef (IDLE, MEM, UPD, ERR), the op encoding constants, and the STACK_BASE/STACK_LIMIT defaults.
REQ-028 Bounds comparison SHALL be one combinational sub-module, stack_bounds_chk, instantiated only when STACK_BOUNDS_CHECK_EN is defined.

Verification
REQ-029 Push 16'hA5A5 at sp_val=16'hFFFF, ack in first MEM cycle -> mem write addr FFFF data A5A5; sp_push=1 with sp_new=FFFE; res_valid two cycles after acceptance.
REQ-030 Pop at sp_val=16'hFFFE, mem_rdata=16'h1234, ack after 3 wait cycles -> mem_addr FFFF, mem_we=0; sp_pop=1 with sp_new=FFFF; res_data=1234 at cycle 5.
REQ-031 Pop at sp_val=16'hFFFF (macro on) -> ERR: res_err=1, err_udf=1, no mem_req, no SP pulse; same stimulus with macro off -> mem_addr 16'h0000, sp_new 16'h0000.
REQ-032 Push at sp_val=16'hFF00 (macro on) -> res_err=1, err_ovf=1 and sticky across a following valid push.
REQ-033 Assert reset during MEM of a push -> mem_req=0 immediately, no sp_push; after release, op_ready=1 and a new push completes normally.

Source files
------------

// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stack_pkg
//  Brief    : Shared types and constants for the stack engine: FSM state
//             encoding, push/pop op encoding, default stack bounds.
//  Revision : 1.0 - initial release
// ============================================================================
package stack_pkg;

    // Engine FSM states; ERR is only reachable with bounds checking built in
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        UPD  = 2'd2,
        ERR  = 2'd3
    } state_t;

    // op_push encoding
    localparam logic c_op_pop  = 1'b0;
    localparam logic c_op_push = 1'b1;

    // Empty-stack SP (also the SP reset value) and lowest legal SP
    localparam logic [15:0] c_stack_base_default  = 16'hFFFF;
    localparam logic [15:0] c_stack_limit_default = 16'hFF00;

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_bounds_chk.sv
`default_nettype none
// ============================================================================
//  Module   : stack_bounds_chk
//  Brief    : Combinational overflow/underflow detection for a requested
//             stack operation against the configured stack bounds.
//  Revision : 1.0 - initial release
// ============================================================================
module stack_bounds_chk
    import stack_pkg::*;
#(
    parameter logic [15:0] STACK_BASE  = c_stack_base_default,
    parameter logic [15:0] STACK_LIMIT = c_stack_limit_default
) (
    input  logic [15:0] sp,
    input  logic        push,
    output logic        ovf,
    output logic        udf
);

    // Push at the limit would write below the stack; pop at base has nothing to read
    always_comb begin
        ovf = (push == c_op_push) && (sp == STACK_LIMIT);
        udf = (push == c_op_pop)  && (sp == STACK_BASE);
    end

endmodule : stack_bounds_chk
`default_nettype wire

// File: rtl/stack_engine.sv
`default_nettype none
// ============================================================================
//  Module   : stack_engine
//  Brief    : Single-outstanding push/pop engine. Push writes mem[SP] then
//             SP-1 (post-decrement); pop reads mem[SP+1] then SP+1
//             (pre-increment). Memory handshake waits indefinitely for ack.
//             Optional bounds checking: define STACK_BOUNDS_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module stack_engine
    import stack_pkg::*;
#(
    parameter logic [15:0] STACK_BASE  = c_stack_base_default,
    parameter logic [15:0] STACK_LIMIT = c_stack_limit_default
) (
    input  logic        clk,
    input  logic        reset,
    // operation request
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_push,
    input  logic [15:0] op_data,
    // completion result
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_err,
    // SP register interface
    input  logic [15:0] sp_val,
    output logic        sp_push,
    output logic        sp_pop,
    output logic [15:0] sp_new,
    // stack memory
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    // sticky error flags
    output logic        err_ovf,
    output logic        err_udf
);

    state_t      r_state;
    logic        r_push;
    logic [15:0] r_sp;

`ifdef STACK_BOUNDS_CHECK_EN
    logic w_ovf;
    logic w_udf;

    // Checked against the live request; these are the values latched on acceptance
    stack_bounds_chk #(
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_bounds_chk (
        .sp   (sp_val),
        .push (op_push),
        .ovf  (w_ovf),
        .udf  (w_udf)
    );
`else
    // Without bounds checking every operation wraps; no error can be raised
    logic w_unused_bounds;
    assign w_unused_bounds = ^{STACK_BASE, STACK_LIMIT};
    assign res_err = 1'b0;
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

    // Control FSM with all outputs registered; reset abandons any memory access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_push    <= 1'b0;
            r_sp      <= 16'h0000;
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= 16'h0000;
            sp_push   <= 1'b0;
            sp_pop    <= 1'b0;
            sp_new    <= 16'h0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
`ifdef STACK_BOUNDS_CHECK_EN
            res_err   <= 1'b0;
            err_ovf   <= 1'b0;
            err_udf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        r_push   <= op_push;
                        r_sp     <= sp_val;
                        op_ready <= 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
                        if (w_ovf || w_udf) begin
                            r_state   <= ERR;
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                            res_data  <= 16'h0000;
                            err_ovf   <= err_ovf | w_ovf;
                            err_udf   <= err_udf | w_udf;
                        end else
`endif
                        begin
                            r_state   <= MEM;
                            mem_req   <= 1'b1;
                            mem_we    <= op_push;
                            mem_wdata <= op_data;
                            // Push writes at SP, pop reads one above it
                            mem_addr  <= (op_push == c_op_push) ? sp_val : sp_val + 16'd1;
                        end
                    end
                end

                MEM: begin
                    if (mem_ack) begin
                        r_state   <= UPD;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        res_valid <= 1'b1;
                        if (r_push == c_op_push) begin
                            sp_push  <= 1'b1;
                            sp_new   <= r_sp - 16'd1;
                            res_data <= 16'h0000;
                        end else begin
                            sp_pop   <= 1'b1;
                            sp_new   <= r_sp + 16'd1;
                            res_data <= mem_rdata;
                        end
                    end
                end

                UPD: begin
                    r_state   <= IDLE;
                    op_ready  <= 1'b1;
                    res_valid <= 1'b0;
                    res_data  <= 16'h0000;
                    sp_push   <= 1'b0;
                    sp_pop    <= 1'b0;
                end

`ifdef STACK_BOUNDS_CHECK_EN
                ERR: begin
                    r_state   <= IDLE;
                    op_ready  <= 1'b1;
                    res_valid <= 1'b0;
                    res_err   <= 1'b0;
                end
`endif

                default: begin
                    r_state   <= IDLE;
                    op_ready  <= 1'b1;
                    res_valid <= 1'b0;
                    sp_push   <= 1'b0;
                    sp_pop    <= 1'b0;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule : stack_engine
`default_nettype wire

// File: tb/tb_stack_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_engine
//  Brief    : Directed self-checking bench for stack_engine (push, pop with
//             wait states, bound/wrap cases, reset during memory access).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stack_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic        op_push;
    logic [15:0] op_data;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_err;
    logic [15:0] sp_val;
    logic        sp_push;
    logic        sp_pop;
    logic [15:0] sp_new;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        err_ovf;
    logic        err_udf;

    int checks = 0;
    int errors = 0;

    stack_engine dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_push   (op_push),
        .op_data   (op_data),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_err   (res_err),
        .sp_val    (sp_val),
        .sp_push   (sp_push),
        .sp_pop    (sp_pop),
        .sp_new    (sp_new),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err_ovf   (err_ovf),
        .err_udf   (err_udf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_push   = 1'b0;
        op_data   = 16'h0000;
        sp_val    = 16'hFFFF;
        mem_rdata = 16'h0000;
        mem_ack   = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk1 ("rst_op_ready",  op_ready,  1'b1);
        chk1 ("rst_mem_req",   mem_req,   1'b0);
        chk1 ("rst_res_valid", res_valid, 1'b0);
        chk1 ("rst_sp_push",   sp_push,   1'b0);
        chk1 ("rst_sp_pop",    sp_pop,    1'b0);
        chk1 ("rst_res_err",   res_err,   1'b0);
        chk1 ("rst_err_ovf",   err_ovf,   1'b0);
        chk1 ("rst_err_udf",   err_udf,   1'b0);
        tick();
        tick();
        reset = 1'b0;
        chk1 ("rel_op_ready", op_ready, 1'b1);

        // ---------------- push A5A5 at FFFF, ack in first MEM cycle ----------------
        op_valid = 1'b1; op_push = 1'b1; op_data = 16'hA5A5; sp_val = 16'hFFFF; mem_ack = 1'b1;
        tick();
        op_valid = 1'b0; sp_val = 16'h1234; op_data = 16'h0000;
        chk1 ("p1_mem_req",   mem_req,   1'b1);
        chk1 ("p1_mem_we",    mem_we,    1'b1);
        chk16("p1_mem_addr",  mem_addr,  16'hFFFF);
        chk16("p1_mem_wdata", mem_wdata, 16'hA5A5);
        chk1 ("p1_op_ready",  op_ready,  1'b0);
        chk1 ("p1_res_valid_c1", res_valid, 1'b0);
        tick();
        chk1 ("p1_res_valid", res_valid, 1'b1);
        chk1 ("p1_sp_push",   sp_push,   1'b1);
        chk1 ("p1_sp_pop",    sp_pop,    1'b0);
        chk16("p1_sp_new",    sp_new,    16'hFFFE);
        chk16("p1_res_data",  res_data,  16'h0000);
        chk1 ("p1_res_err",   res_err,   1'b0);
        chk1 ("p1_mem_req_upd", mem_req, 1'b0);
        chk1 ("p1_op_ready_upd", op_ready, 1'b0);
        mem_ack = 1'b0;
        tick();
        chk1 ("p1_idle_res_valid", res_valid, 1'b0);
        chk1 ("p1_idle_sp_push",   sp_push,   1'b0);
        chk1 ("p1_idle_op_ready",  op_ready,  1'b1);

        // ---------------- pop at FFFE, 3 wait cycles ----------------
        op_valid = 1'b1; op_push = 1'b0; sp_val = 16'hFFFE; mem_rdata = 16'h1234; mem_ack = 1'b0;
        tick();
        op_valid = 1'b0; sp_val = 16'h0000;
        chk16("p2_mem_addr", mem_addr, 16'hFFFF);
        chk1 ("p2_mem_we",   mem_we,   1'b0);
        for (int i = 0; i < 3; i++) begin
            chk1 ("p2_wait_mem_req",   mem_req,   1'b1);
            chk16("p2_wait_mem_addr",  mem_addr,  16'hFFFF);
            chk1 ("p2_wait_res_valid", res_valid, 1'b0);
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk1 ("p2_res_valid", res_valid, 1'b1);
        chk16("p2_res_data",  res_data,  16'h1234);
        chk1 ("p2_sp_pop",    sp_pop,    1'b1);
        chk1 ("p2_sp_push",   sp_push,   1'b0);
        chk16("p2_sp_new",    sp_new,    16'hFFFF);
        tick();
        chk1 ("p2_idle_sp_pop", sp_pop, 1'b0);
        chk1 ("p2_idle_op_ready", op_ready, 1'b1);

        // ---------------- pop at empty stack FFFF ----------------
        op_valid = 1'b1; op_push = 1'b0; sp_val = 16'hFFFF; mem_rdata = 16'hBEEF;
        tick();
        op_valid = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
        chk1 ("udf_res_valid", res_valid, 1'b1);
        chk1 ("udf_res_err",   res_err,   1'b1);
        chk16("udf_res_data",  res_data,  16'h0000);
        chk1 ("udf_err_udf",   err_udf,   1'b1);
        chk1 ("udf_mem_req",   mem_req,   1'b0);
        chk1 ("udf_sp_pop",    sp_pop,    1'b0);
        tick();
        chk1 ("udf_idle_op_ready", op_ready, 1'b1);
        chk1 ("udf_sticky",        err_udf,  1'b1);
        chk1 ("udf_idle_res_err",  res_err,  1'b0);
`else
        chk1 ("wrap_pop_mem_req",  mem_req,  1'b1);
        chk16("wrap_pop_mem_addr", mem_addr, 16'h0000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk1 ("wrap_pop_sp_pop",   sp_pop,   1'b1);
        chk16("wrap_pop_sp_new",   sp_new,   16'h0000);
        chk16("wrap_pop_res_data", res_data, 16'hBEEF);
        chk1 ("wrap_pop_res_err",  res_err,  1'b0);
        tick();
`endif

        // ---------------- push at limit FF00 ----------------
        op_valid = 1'b1; op_push = 1'b1; op_data = 16'h7777; sp_val = 16'hFF00;
        tick();
        op_valid = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
        chk1 ("ovf_res_err", res_err, 1'b1);
        chk1 ("ovf_err_ovf", err_ovf, 1'b1);
        chk1 ("ovf_mem_req", mem_req, 1'b0);
        chk1 ("ovf_sp_push", sp_push, 1'b0);
        tick();
        op_valid = 1'b1; op_push = 1'b1; op_data = 16'h1111; sp_val = 16'hFFF0; mem_ack = 1'b1;
        tick();
        op_valid = 1'b0;
        chk16("ovf_next_mem_addr", mem_addr, 16'hFFF0);
        tick();
        mem_ack = 1'b0;
        chk1 ("ovf_next_sp_push", sp_push, 1'b1);
        chk16("ovf_next_sp_new",  sp_new,  16'hFFEF);
        chk1 ("ovf_next_res_err", res_err, 1'b0);
        chk1 ("ovf_sticky",       err_ovf, 1'b1);
        tick();
`else
        chk1 ("lim_push_mem_req",   mem_req,   1'b1);
        chk16("lim_push_mem_addr",  mem_addr,  16'hFF00);
        chk16("lim_push_mem_wdata", mem_wdata, 16'h7777);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk1 ("lim_push_sp_push", sp_push, 1'b1);
        chk16("lim_push_sp_new",  sp_new,  16'hFEFF);
        chk1 ("lim_push_err_ovf", err_ovf, 1'b0);
        tick();
`endif

        // ---------------- reset during MEM of a push ----------------
        op_valid = 1'b1; op_push = 1'b1; op_data = 16'hC3C3; sp_val = 16'h8000; mem_ack = 1'b0;
        tick();
        op_valid = 1'b0;
        chk1 ("rmem_mem_req_before", mem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1 ("rmem_mem_req_now", mem_req,  1'b0);
        chk1 ("rmem_sp_push",     sp_push,  1'b0);
        chk1 ("rmem_op_ready",    op_ready, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        chk1 ("rmem_rel_op_ready", op_ready, 1'b1);
        chk1 ("rmem_rel_sp_push",  sp_push,  1'b0);
        chk1 ("rmem_rel_mem_req",  mem_req,  1'b0);
        chk1 ("rmem_rel_err_ovf",  err_ovf,  1'b0);
        chk1 ("rmem_rel_err_udf",  err_udf,  1'b0);
        op_valid = 1'b1; op_push = 1'b1; op_data = 16'h5A5A; sp_val = 16'h8000; mem_ack = 1'b1;
        tick();
        op_valid = 1'b0;
        chk16("rmem_new_mem_addr",  mem_addr,  16'h8000);
        chk16("rmem_new_mem_wdata", mem_wdata, 16'h5A5A);
        tick();
        mem_ack = 1'b0;
        chk1 ("rmem_new_res_valid", res_valid, 1'b1);
        chk1 ("rmem_new_sp_push",   sp_push,   1'b1);
        chk16("rmem_new_sp_new",    sp_new,    16'h7FFF);
        tick();
        chk1 ("rmem_new_idle", op_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_stack_engine
`default_nettype wire
